// File: rtl/exec_dispatch_if.sv
// ---------------------------------------------------------------------------
// exec_dispatch_if
//   Bundles the issue, functional-unit and writeback signals of the execute
//   stage dispatcher.
//
//   master : the surrounding pipeline (decode, functional units, writeback)
//   slave  : exec_dispatch
//
//   issue_valid / issue_unit / issue_ready : decoded operation handshake
//   flush                                  : discard queued/in-flight work
//   unit_start / unit_done / unit_ack      : per functional unit control
//   p_sel / wb_valid / wb_ready            : writeback priority mux control
//   occupancy                              : entries in the completion queue
// ---------------------------------------------------------------------------
interface exec_dispatch_if #(
    parameter int NUM_UNITS = 7
);
    logic                 issue_valid;
    logic [2:0]           issue_unit;
    logic                 issue_ready;
    logic                 flush;
    logic [NUM_UNITS-1:0] unit_start;
    logic [NUM_UNITS-1:0] unit_done;
    logic [NUM_UNITS-1:0] unit_ack;
    logic [2:0]           p_sel;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [2:0]           occupancy;

    modport master (
        output issue_valid, issue_unit, flush, unit_done, wb_ready,
        input  issue_ready, unit_start, unit_ack, p_sel, wb_valid, occupancy
    );

    modport slave (
        input  issue_valid, issue_unit, flush, unit_done, wb_ready,
        output issue_ready, unit_start, unit_ack, p_sel, wb_valid, occupancy
    );
endinterface

// File: rtl/exec_dispatch.sv
// ---------------------------------------------------------------------------
// exec_dispatch
//   In-order issue and completion tracker for the execute stage.
//   Accepts one operation per cycle, pulses the target unit's start one
//   cycle later, and keeps the unit codes in program order so that the
//   writeback mux (p_sel) retires results strictly in issue order. Each
//   retired unit is acked in the same cycle it is consumed. A flush empties
//   the queue; finished units are drained with a registered ack, unfinished
//   ones are marked discard and acked when their late done arrives.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : exec_dispatch_if.slave (issue / unit / writeback signals)
//
// Parameters:
//   DEPTH     : completion queue entries, 2..7
//   NUM_UNITS : functional units (codes ALU..FADD_SUBU)
// ---------------------------------------------------------------------------
module exec_dispatch #(
    parameter int DEPTH     = 4,
    parameter int NUM_UNITS = 7
) (
    input  logic           clk,
    input  logic           reset,
    exec_dispatch_if.slave bus
);
    typedef enum logic [2:0] {
        ALU       = 3'd0,
        FPU       = 3'd1,
        MULU      = 3'd2,
        DIVU      = 3'd3,
        FMULU     = 3'd4,
        FDIVU     = 3'd5,
        FADD_SUBU = 3'd6,
        UNIT_RSVD = 3'd7
    } priority_t;

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Queue storage is data: written on push only, never reset.
    priority_t            q_mem [DEPTH];

    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [2:0]           count;
    logic [NUM_UNITS-1:0] busy;
    logic [NUM_UNITS-1:0] done_q;
    logic [NUM_UNITS-1:0] discard;
    logic [NUM_UNITS-1:0] start_p1;
    logic [NUM_UNITS-1:0] ack_p1;

    priority_t            issue_code;
    priority_t            head_unit;
    logic [NUM_UNITS-1:0] issue_oh;
    logic [NUM_UNITS-1:0] head_oh;
    logic [NUM_UNITS-1:0] pop_oh;
    logic [NUM_UNITS-1:0] done_hit;
    logic [NUM_UNITS-1:0] disc_done;
    logic [NUM_UNITS-1:0] drain;
    logic                 issue_ready_c;
    logic                 wb_valid_c;
    logic                 push;
    logic                 pop;

    // ---- stage p0: combinational decode of issue / head / completions ----
    always_comb begin
        // Code 7 has no unit behind it; route it to the ALU.
        issue_code    = (bus.issue_unit == 3'd7) ? ALU : priority_t'(bus.issue_unit);
        head_unit     = (count != 3'd0) ? q_mem[head] : ALU;
        issue_oh      = NUM_UNITS'(1) << issue_code;
        head_oh       = NUM_UNITS'(1) << head_unit;

        issue_ready_c = !bus.flush && (count != DEPTH_C) && ((busy & issue_oh) == '0);
        wb_valid_c    = (count != 3'd0) && ((done_q & head_oh) != '0) && !bus.flush;
        push          = bus.issue_valid && issue_ready_c;
        pop           = wb_valid_c && bus.wb_ready;
        pop_oh        = pop ? head_oh : '0;

        // A done only counts for units we actually launched.
        done_hit      = bus.unit_done & busy & ~discard;
        disc_done     = bus.unit_done & busy & discard;

        // On flush every live, non-discarded unit that has finished (or
        // finishes this very cycle) is released; the rest become discards.
        drain         = bus.flush ? (busy & ~discard & (done_q | done_hit)) : '0;
    end

    assign bus.issue_ready = issue_ready_c;
    assign bus.wb_valid    = wb_valid_c;
    assign bus.p_sel       = head_unit;
    assign bus.occupancy   = count;
    assign bus.unit_start  = start_p1;
    // Registered acks only target units outside the queue, so they can
    // never coincide with the head's retire ack.
    assign bus.unit_ack    = ack_p1 | pop_oh;

    // ---- stage p1: queue storage ----
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[tail] <= issue_code;
        end
    end

    // ---- stage p1: control state, start and deferred-ack registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            busy     <= '0;
            done_q   <= '0;
            discard  <= '0;
            start_p1 <= '0;
            ack_p1   <= '0;
        end else begin
            start_p1 <= push ? issue_oh : '0;
            ack_p1   <= drain | disc_done;

            if (bus.flush) begin
                // issue_ready and wb_valid are both low here, so no push/pop.
                head    <= tail;
                count   <= '0;
                busy    <= busy & ~drain & ~disc_done;
                // done_q is only ever set on non-discarded busy units, all of
                // which are drained above.
                done_q  <= '0;
                discard <= (discard & ~disc_done) | (busy & ~discard & ~drain);
            end else begin
                if (push) begin
                    tail <= ptr_inc(tail);
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                if (push && !pop) begin
                    count <= count + 3'd1;
                end else if (pop && !push) begin
                    count <= count - 3'd1;
                end
                busy    <= (busy | (push ? issue_oh : '0)) & ~pop_oh & ~disc_done;
                done_q  <= (done_q | done_hit) & ~pop_oh;
                discard <= discard & ~disc_done;
            end
        end
    end
endmodule

// File: doc/exec_dispatch.md
# exec_dispatch

In-order issue and completion tracker for the execute stage. It accepts one decoded operation per cycle tagged with a functional-unit code and pulses that unit's start. It queues the unit codes in program order and drives `p_sel` of the writeback priority mux so results retire strictly in issue order. It also acknowledges each unit when its result is consumed, and drains in-flight units on a pipeline flush.

## Interface
Parameters:
- `DEPTH`, default 4: in-order completion queue entries. Legal range 2..7. A unit can appear at most once in the queue.
- `NUM_UNITS`, default 7: functional units, indexed by `priority_t` codes ALU=0, FPU=1, MULU=2, DIVU=3, FMULU=4, FDIVU=5, FADD_SUBU=6.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `issue_valid` input 1: an operation is offered.
- `issue_unit` input 3 (`priority_t`): target unit. Code 7 is treated as ALU.
- `issue_ready` output 1: the operation is accepted when `issue_valid && issue_ready`.
- `flush` input 1: discard all queued and in-flight operations.
- `unit_start` output NUM_UNITS: one-hot start pulse, 1 cycle.
- `unit_done` input NUM_UNITS: per-unit done pulse. The unit holds its result until acked.
- `unit_ack` output NUM_UNITS: per-unit release pulse, 1 cycle.
- `p_sel` output 3 (`priority_t`): unit at the queue head. ALU when the queue is empty.
- `wb_valid` output 1: the head unit's result is ready on the mux.
- `wb_ready` input 1: writeback consumes the result.
- `occupancy` output 3: number of queued entries.

## Operation
State:
- Circular queue of unit codes: `head` and `tail` pointers wrapping modulo DEPTH, plus a `count` register.
- Per-unit bits: `busy`, `done_q` and `discard`.
- A registered one-hot start vector.
- A registered drain-ack vector.

Issue:
- `issue_ready = !flush && count != DEPTH && !busy[unit]`.
- On handshake, the unit code is written at `tail`, `tail` increments and `busy[unit]` sets.
- `unit_start[unit]` pulses in the next cycle.

Completion:
- `unit_done[u]` with `busy[u] && !discard[u]` sets `done_q[u]`.
- `unit_done` on a non-busy unit is ignored.

Retire:
- `wb_valid = count != 0 && done_q[head_unit] && !flush`.
- On `wb_valid && wb_ready`:
  - `unit_ack[head_unit]` pulses combinationally in the same cycle.
  - `head` increments.
  - `busy` and `done_q` clear for that unit at the edge.
- If push and pop occur in the same cycle, `count` is unchanged.

Flush, at the edge where `flush` is high:
- Queue empties: `head = tail`, `count = 0`.
- Each busy unit with `done_q` set gets a drain ack, registered, so it pulses the next cycle. Its `busy` and `done_q` clear.
- Each busy unit without `done_q` sets `discard`.
- A later `unit_done` on a discarded unit produces a registered `unit_ack` the next cycle and clears `busy` and `discard`. It produces no `wb_valid`.
- A start registered in the flush cycle still fires. That unit becomes busy and discarded.

Reset values: `unit_start` = 0, `unit_ack` = 0, `wb_valid` = 0, `p_sel` = ALU, `occupancy` = 0, all `busy`, `done_q` and `discard` bits = 0, pointers = 0. Reset mid-operation drops everything with no acks issued.

## Timing
- Issue-to-start latency: 1 cycle.
- `unit_done` to `wb_valid`: 1 cycle.
- `wb_ready` to ack: 0 cycles, combinational.
- Throughput: 1 issue and 1 retire per cycle. A full queue blocks issue even if a pop occurs in the same cycle.
- `p_sel` is combinational from `head` and changes the cycle after a pop.
- Drain acks and flush-case acks are registered, 1 cycle after the triggering edge. They never collide with retire acks, because a drained unit is never at the queue head.

## Test plan
- **Basic issue and retire:** issue MULU at cycle 0 → `unit_start` = 0b0000100 at cycle 1. `unit_done[2]` at cycle 4 → `wb_valid` = 1 and `p_sel` = MULU at cycle 5. `wb_ready` = 1 → `unit_ack[2]` in the same cycle, `occupancy` returns to 0.
- **Out-of-order completion, in-order retire:** issue DIVU then ALU. ALU done at cycle 2, DIVU done at cycle 9 → `wb_valid` stays 0 until cycle 10 with `p_sel` = DIVU. ALU retires the cycle after DIVU retires.
- **Full and busy back-pressure:** DEPTH=4. Issue ALU, FPU, MULU, DIVU with no completions → `issue_ready` = 0 with `occupancy` = 4. Re-issuing FPU while it is busy, with `occupancy` < 4, → `issue_ready` = 0.
- **Flush:** FMULU done and pending, FDIVU in flight. Assert `flush` → `wb_valid` = 0, `unit_ack[4]` next cycle, `occupancy` = 0. A later `unit_done[5]` → `unit_ack[5]` one cycle later and no `wb_valid`.
- **Wrap-around:** stream 10 ALU-only issue/retire pairs through DEPTH=4 → correct `p_sel` every retire and `occupancy` never exceeds 1.
- **Asynchronous reset:** assert `reset` mid-division → all outputs go to their reset values immediately. `unit_done[3]` after reset is ignored.
